// File: rtl/pa_dcache_inv_arb.sv
`default_nettype none
// ============================================================================
// Module   : pa_dcache_inv_arb
// Brief    : Arbitrates dcache tag/dirty array ports between the LSU pipeline
//            and a whole-cache invalidate walk that zeroes every index.
// Revision : 1.0
// ============================================================================
module pa_dcache_inv_arb #(
    parameter int INV_IDX_MAX = 1023
) (
    input  logic        forever_cpuclk,
    input  logic        cpurst,
    input  logic        cp0_lsu_dcache_inv_req,
    output logic        lsu_dcache_inv_busy,
    output logic        lsu_dcache_inv_done,
    input  logic        pipe_req,
    output logic        pipe_gnt,
    input  logic [9:0]  pipe_idx,
    input  logic [1:0]  pipe_tag_wen,
    input  logic [22:0] pipe_tag_din,
    input  logic [2:0]  pipe_dirty_wen,
    input  logic [2:0]  pipe_dirty_din,
    output logic        dcache_tag_cen,
    output logic [1:0]  dcache_tag_wen,
    output logic [22:0] dcache_tag_din,
    output logic [9:0]  dcache_tag_idx,
    output logic        dcache_dirty_cen,
    output logic [2:0]  dcache_dirty_wen,
    output logic [2:0]  dcache_dirty_din,
    output logic [9:0]  dcache_dirty_idx
);

    localparam logic [1:0] c_s_idle  = 2'd0;
    localparam logic [1:0] c_s_inv   = 2'd1;
    localparam logic [1:0] c_s_done  = 2'd2;
    localparam logic [9:0] c_idx_max = 10'(INV_IDX_MAX);

    logic [1:0] r_state;
    logic [9:0] r_inv_cnt;

    // The counter stops at the last index; DONE is entered instead of wrapping.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            r_state   <= c_s_idle;
            r_inv_cnt <= 10'd0;
        end else begin
            case (r_state)
                c_s_idle: begin
                    if (cp0_lsu_dcache_inv_req) begin
                        r_state   <= c_s_inv;
                        r_inv_cnt <= 10'd0;
                    end
                end
                c_s_inv: begin
                    if (r_inv_cnt == c_idx_max) begin
                        r_state <= c_s_done;
                    end else begin
                        r_inv_cnt <= r_inv_cnt + 10'd1;
                    end
                end
                c_s_done: begin
                    r_state <= c_s_idle;
                end
                default: begin
                    r_state <= c_s_idle;
                end
            endcase
        end
    end

    // Array ports idle by default; reset overrides everything combinationally.
    always_comb begin
        pipe_gnt            = 1'b0;
        lsu_dcache_inv_busy = 1'b0;
        lsu_dcache_inv_done = 1'b0;
        dcache_tag_cen      = 1'b1;
        dcache_tag_wen      = 2'b11;
        dcache_tag_din      = 23'd0;
        dcache_tag_idx      = 10'd0;
        dcache_dirty_cen    = 1'b1;
        dcache_dirty_wen    = 3'b111;
        dcache_dirty_din    = 3'd0;
        dcache_dirty_idx    = 10'd0;
        if (!cpurst) begin
            case (r_state)
                c_s_idle: begin
                    pipe_gnt = pipe_req;
                    if (pipe_req) begin
                        dcache_tag_cen   = 1'b0;
                        dcache_tag_wen   = pipe_tag_wen;
                        dcache_tag_din   = pipe_tag_din;
                        dcache_tag_idx   = pipe_idx;
                        dcache_dirty_cen = 1'b0;
                        dcache_dirty_wen = pipe_dirty_wen;
                        dcache_dirty_din = pipe_dirty_din;
                        dcache_dirty_idx = pipe_idx;
                    end
                end
                c_s_inv: begin
                    lsu_dcache_inv_busy = 1'b1;
                    dcache_tag_cen      = 1'b0;
                    dcache_tag_wen      = 2'b00;
                    dcache_tag_idx      = r_inv_cnt;
                    dcache_dirty_cen    = 1'b0;
                    dcache_dirty_wen    = 3'b000;
                    dcache_dirty_idx    = r_inv_cnt;
                end
                c_s_done: begin
                    lsu_dcache_inv_busy = 1'b1;
                    lsu_dcache_inv_done = 1'b1;
                end
                default: begin
                    lsu_dcache_inv_busy = 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/pa_dcache_inv_arb.md
PA_DCACHE_INV_ARB -- requirements
Module: pa_dcache_inv_arb

Interface
REQ-001 Parameter: INV_IDX_MAX, default 1023, last tag/dirty index written by the invalidate walk; benches may reduce it to shorten runs.
REQ-002 Port: forever_cpuclk  input  1  the single clock; all state changes on its rising edge.
REQ-003 Port: cpurst  input  1  reset, synchronous and active-high.
REQ-004 Port: cp0_lsu_dcache_inv_req  input  1  level request to invalidate the whole dcache (tag and dirty arrays, both ways).
REQ-005 Port: lsu_dcache_inv_busy  output  1  high while the invalidate walk owns the arrays.
REQ-006 Port: lsu_dcache_inv_done  output  1  one-cycle pulse when the walk completes.
REQ-007 Port: pipe_req  input  1  the LSU pipeline requests a tag/dirty array access this cycle.
REQ-008 Port: pipe_gnt  output  1  the pipeline access is driven onto the arrays this cycle.
REQ-009 Port: pipe_idx  input  10  tag/dirty index for the pipeline access.
REQ-010 Port: pipe_tag_wen  input  2  per-way tag write enable, active-low.
REQ-011 Port: pipe_tag_din  input  23  tag write data.
REQ-012 Port: pipe_dirty_wen  input  3  dirty-array bit write enable, active-low.
REQ-013 Port: pipe_dirty_din  input  3  dirty-array write data.
REQ-014 Ports, all outputs, same widths and meanings as the dcache array ports: dcache_tag_cen (1, active-low), dcache_tag_wen (2), dcache_tag_din (23), dcache_tag_idx (10), dcache_dirty_cen (1, active-low), dcache_dirty_wen (3), dcache_dirty_din (3), dcache_dirty_idx (10).

Function
REQ-015 States: IDLE, INV, DONE, held in a state register; one 10-bit walk counter, inv_cnt.
REQ-016 IDLE with cp0_lsu_dcache_inv_req=1: next state INV, and inv_cnt loads 0.
REQ-017 INV, each cycle:
- drive tag_cen=0, tag_wen=2'b00, tag_din=0, tag_idx=inv_cnt;
- drive dirty_cen=0, dirty_wen=3'b000, dirty_din=0, dirty_idx=inv_cnt.
REQ-018 INV with inv_cnt<INV_IDX_MAX: inv_cnt increments by 1; INV with inv_cnt==INV_IDX_MAX: next state DONE, and the counter does not wrap.
REQ-019 DONE: lsu_dcache_inv_done=1 for exactly one cycle, arrays idle (both cen=1), next state IDLE.
REQ-020 lsu_dcache_inv_busy is 1 in INV and DONE, 0 in IDLE.
REQ-021 Latency: the accepting cycle is T, the first write is at T+1, the last write at T+1+INV_IDX_MAX, and done is at T+2+INV_IDX_MAX.
REQ-022 In IDLE the arrays follow the pipeline combinationally:
- pipe_gnt = pipe_req;
- when pipe_req=1, tag/dirty cen = 0 and wen/din/idx = the pipe_* inputs, with pipe_idx driving both tag_idx and dirty_idx.
REQ-023 In IDLE with pipe_req=0: both cen=1, all wen bits 1, din=0, idx=0.
REQ-024 In INV and DONE: pipe_gnt=0 and the pipe_* inputs are ignored; the requester must hold pipe_req until it is granted.
REQ-025 Simultaneous pipe_req and inv_req in IDLE: the pipeline is granted that cycle and the walk starts the next cycle.
REQ-026 cp0_lsu_dcache_inv_req is ignored in INV and DONE; if it is still high on return to IDLE, a new walk starts (level semantics).
REQ-027 Every array write enable is active-low, and every wen bit is 1 whenever its cen=1.

Reset
REQ-028 cpurst=1 at a rising edge: state=IDLE, inv_cnt=0.
REQ-029 While cpurst=1, outputs are forced combinationally, regardless of other inputs:
- both cen=1, all wen bits 1;
- pipe_gnt=0, busy=0, done=0.
REQ-030 Reset during INV or DONE aborts the walk with no done pulse; after cpurst is released, behaviour restarts from IDLE.

Verification
REQ-031 INV_IDX_MAX=3; inv_req pulsed for 1 cycle at T -> tag/dirty writes at idx 0,1,2,3 in cycles T+1..T+4, with tag_wen=00, dirty_wen=000, din=0; done=1 at T+5 only; busy=1 over T+1..T+5.
REQ-032 IDLE, pipe_req=1, pipe_idx=10'h155, pipe_tag_wen=2'b10, pipe_tag_din=23'h7FFFFF -> same cycle pipe_gnt=1, tag_cen=0, tag_idx=10'h155, tag_wen=2'b10, dirty_idx=10'h155.
REQ-033 inv_req and pipe_req both 1 at T -> pipe_gnt=1 at T; pipe_gnt=0 from T+1 through done; pipe_gnt=1 in the first IDLE cycle after done while pipe_req is still held.
REQ-034 inv_req held high continuously, INV_IDX_MAX=1 -> walk, done, one IDLE cycle, walk, repeating; no counter wrap past 1.
REQ-035 cpurst asserted at the second walk cycle (inv_cnt=1) -> next cycle both cen=1, busy=0, and no done pulse; after release with inv_req=0 the block stays IDLE.
REQ-036 Default INV_IDX_MAX=1023 -> exactly 1024 distinct indices are written, the last at idx 10'h3FF, with done 1025 cycles after the request was accepted.
